// File: rtl/mat_vec_issue.sv
// Operand sequencer for fp32_mul: streams the 16 M[row][col] / v[col] pairs of a
// 4x4 matrix-vector product, one pair per cycle, tagged with row/col/last.
module mat_vec_issue (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         mat_we_in,
   input  logic [3:0]   mat_addr_in,
   input  logic [31:0]  mat_data_in,
   input  logic         vtx_valid_in,
   output logic         vtx_ready_out,
   input  logic [127:0] vtx_in,
   output logic         valid_out,
   output logic [31:0]  a_out,
   output logic [31:0]  b_out,
   output logic [1:0]   row_out,
   output logic [1:0]   col_out,
   output logic         last_out,
   output logic         busy_out
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [31:0]        FP_ONE   = 32'h3F80_0000;
   localparam logic [15:0][31:0]  IDENTITY = {FP_ONE, 128'h0, FP_ONE, 128'h0, FP_ONE, 128'h0, FP_ONE};

   state_t            state_q;
   logic [3:0]        k_q;
   logic [15:0][31:0] mat_q;
   logic [3:0][31:0]  vtx_q;
   logic              valid_q;
   logic              last_q;
   logic [31:0]       a_q;
   logic [31:0]       b_q;

   logic              accept;
   logic              wr_ok;
   logic              issue_d;
   logic [3:0]        k_d;
   logic [31:0]       a_d;
   logic [31:0]       b_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      vtx_ready_out = (state_q == IDLE) || (state_q == ISSUE && k_q == 4'd15);
      accept        = vtx_valid_in && vtx_ready_out;
      wr_ok         = mat_we_in && (!valid_q || last_q);
      issue_d       = accept || (state_q == ISSUE && k_q != 4'd15);
      k_d           = accept ? 4'd0 : k_q + 4'd1;
      // Forward a same-edge write so the pair being loaded sees the new element.
      a_d           = (wr_ok && mat_addr_in == k_d) ? mat_data_in : mat_q[k_d];
      b_d           = accept ? vtx_in[31:0] : vtx_q[k_d[1:0]];
   end

   // NOTE: sequential state uses non-blocking assignments only; the matrix is reset on
   // purpose because consumers rely on it coming back as identity.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         k_q     <= 4'd0;
         mat_q   <= IDENTITY;
         vtx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
      end else begin
         if (wr_ok) begin
            mat_q[mat_addr_in] <= mat_data_in;
         end
         if (accept) begin
            vtx_q <= vtx_in;
         end
         if (issue_d) begin
            state_q <= ISSUE;
            k_q     <= k_d;
            valid_q <= 1'b1;
            last_q  <= (k_d == 4'd15);
            a_q     <= a_d;
            b_q     <= b_d;
         end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end

   assign valid_out = valid_q;
   assign busy_out  = valid_q;
   assign last_out  = last_q;
   assign a_out     = a_q;
   assign b_out     = b_q;
   assign row_out   = k_q[3:2];
   assign col_out   = k_q[1:0];

endmodule

// File: tb/tb_mat_vec_issue.sv
// Directed bench for mat_vec_issue: drives and samples 1 time unit after each
// rising edge, with hand-derived expected operand pairs.
module tb_mat_vec_issue;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic         mat_we_in;
   logic [3:0]   mat_addr_in;
   logic [31:0]  mat_data_in;
   logic         vtx_valid_in;
   logic         vtx_ready_out;
   logic [127:0] vtx_in;
   logic         valid_out;
   logic [31:0]  a_out;
   logic [31:0]  b_out;
   logic [1:0]   row_out;
   logic [1:0]   col_out;
   logic         last_out;
   logic         busy_out;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] ONE = 32'h3F80_0000;

   mat_vec_issue dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .mat_we_in     (mat_we_in),
      .mat_addr_in   (mat_addr_in),
      .mat_data_in   (mat_data_in),
      .vtx_valid_in  (vtx_valid_in),
      .vtx_ready_out (vtx_ready_out),
      .vtx_in        (vtx_in),
      .valid_out     (valid_out),
      .a_out         (a_out),
      .b_out         (b_out),
      .row_out       (row_out),
      .col_out       (col_out),
      .last_out      (last_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
   endtask

   task automatic send_vertex(input logic [127:0] v);
      vtx_valid_in = 1'b1;
      vtx_in       = v;
      tick();
      vtx_valid_in = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && valid_out; i++) tick();
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL %s drain: valid_out still %b after 40 cycles, expected 0", name, valid_out);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick();
      n_checks++;
      if ({valid_out, busy_out, last_out, vtx_ready_out} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_flags: got v/b/l/r=%b, expected 0001", {valid_out, busy_out, last_out, vtx_ready_out});
      end
      n_checks++;
      if ({a_out, b_out, row_out, col_out} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_data: got a=%h b=%h row=%0d col=%0d, expected all 0", a_out, b_out, row_out, col_out);
      end
      rst_in = 1'b0;
   endtask

   task automatic test_identity();
      logic [31:0] vv [4];
      logic [31:0] exp_a;
      vv[0] = 32'h3F80_0000; vv[1] = 32'h4000_0000; vv[2] = 32'h4040_0000; vv[3] = 32'h4080_0000;
      send_vertex({vv[3], vv[2], vv[1], vv[0]});
      for (int k = 0; k < 16; k++) begin
         exp_a = (k / 4 == k % 4) ? ONE : 32'h0;
         n_checks++;
         if (valid_out !== 1'b1 || busy_out !== 1'b1 || last_out !== (k == 15)) begin
            n_fail++;
            $display("FAIL identity_ctl k=%0d: got valid=%b busy=%b last=%b, expected 1 1 %b", k, valid_out, busy_out, last_out, k == 15);
         end
         n_checks++;
         if (a_out !== exp_a || b_out !== vv[k % 4] || row_out !== 2'(k / 4) || col_out !== 2'(k % 4)) begin
            n_fail++;
            $display("FAIL identity_pair k=%0d: got a=%h b=%h row=%0d col=%0d, expected a=%h b=%h row=%0d col=%0d",
                     k, a_out, b_out, row_out, col_out, exp_a, vv[k % 4], k / 4, k % 4);
         end
         tick();
      end
      n_checks++;
      if (valid_out !== 1'b0 || vtx_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL identity_end: got valid=%b ready=%b, expected 0 1", valid_out, vtx_ready_out);
      end
   endtask

   task automatic test_loaded_element();
      mat_we_in = 1'b1; mat_addr_in = 4'b1001; mat_data_in = 32'h4397_0FFD;
      tick();
      mat_we_in = 1'b0;
      send_vertex({32'h0, 32'h0, 32'h40C9_1759, 32'h0});
      repeat (9) tick();
      n_checks++;
      if (a_out !== 32'h4397_0FFD || b_out !== 32'h40C9_1759 || row_out !== 2'd2 || col_out !== 2'd1) begin
         n_fail++;
         $display("FAIL loaded_k9: got a=%h b=%h row=%0d col=%0d, expected a=43970ffd b=40c91759 row=2 col=1",
                  a_out, b_out, row_out, col_out);
      end
      drain("loaded");
   endtask

   task automatic test_back_to_back();
      vtx_valid_in = 1'b1;
      vtx_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      tick();
      for (int c = 0; c < 32; c++) begin
         n_checks++;
         if (valid_out !== 1'b1 || last_out !== (c == 15 || c == 31)) begin
            n_fail++;
            $display("FAIL b2b_ctl c=%0d: got valid=%b last=%b, expected 1 %b", c, valid_out, last_out, c == 15 || c == 31);
         end
         if (c < 16) begin
            n_checks++;
            if (vtx_ready_out !== (c == 15)) begin
               n_fail++;
               $display("FAIL b2b_ready c=%0d: got %b, expected %b", c, vtx_ready_out, c == 15);
            end
         end
         if (c == 0 || c == 16) begin
            n_checks++;
            if (b_out !== (c == 0 ? 32'hA0 : 32'hB0)) begin
               n_fail++;
               $display("FAIL b2b_vertex c=%0d: got b=%h, expected %h", c, b_out, c == 0 ? 32'hA0 : 32'hB0);
            end
         end
         if (c == 15) vtx_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
         if (c == 16) vtx_valid_in = 1'b0;
         tick();
      end
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: got valid=%b, expected 0", valid_out);
      end
   endtask

   task automatic test_write_gating();
      logic [127:0] v = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, ONE};
      send_vertex(v);
      repeat (7) tick();
      mat_we_in = 1'b1; mat_addr_in = 4'd0; mat_data_in = 32'h40A0_0000;
      tick();
      mat_we_in = 1'b0;
      drain("gate_mid");
      send_vertex(v);
      n_checks++;
      if (a_out !== ONE) begin
         n_fail++;
         $display("FAIL gate_dropped: got a=%h at k=0, expected 3f800000", a_out);
      end
      repeat (15) tick();
      // Boundary cycle (k=15, no new vertex): write to M[1][1] must land.
      mat_we_in = 1'b1; mat_addr_in = 4'd5; mat_data_in = 32'h4100_0000;
      tick();
      mat_we_in = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL gate_boundary_idle: got valid=%b, expected 0", valid_out);
      end
      mat_we_in = 1'b1; mat_addr_in = 4'd0; mat_data_in = 32'h40A0_0000;
      send_vertex(v);
      mat_we_in = 1'b0;
      n_checks++;
      if (a_out !== 32'h40A0_0000) begin
         n_fail++;
         $display("FAIL gate_accept_edge: got a=%h at k=0, expected 40a00000", a_out);
      end
      repeat (5) tick();
      n_checks++;
      if (a_out !== 32'h4100_0000 || b_out !== 32'h4000_0000) begin
         n_fail++;
         $display("FAIL gate_boundary_write: got a=%h b=%h at k=5, expected 41000000 40000000", a_out, b_out);
      end
      drain("gate_end");
   endtask

   task automatic test_reset_mid_issue();
      send_vertex({32'h4, 32'h3, 32'h2, 32'h1});
      repeat (7) tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0 || vtx_ready_out !== 1'b1 || last_out !== 1'b0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flags: got valid=%b ready=%b last=%b busy=%b, expected 0 1 0 0",
                  valid_out, vtx_ready_out, last_out, busy_out);
      end
      send_vertex({32'h4, 32'h3, 32'h2, 32'h1});
      n_checks++;
      if (a_out !== ONE || b_out !== 32'h1) begin
         n_fail++;
         $display("FAIL midrst_k0: got a=%h b=%h, expected 3f800000 00000001", a_out, b_out);
      end
      repeat (5) tick();
      n_checks++;
      if (a_out !== ONE) begin
         n_fail++;
         $display("FAIL midrst_k5: got a=%h, expected 3f800000", a_out);
      end
      drain("midrst");
   endtask

   task automatic test_handshake_stability();
      logic [31:0] vv [4];
      vv[0] = 32'h1111_1111; vv[1] = 32'h2222_2222; vv[2] = 32'h3333_3333; vv[3] = 32'h4444_4444;
      send_vertex({vv[3], vv[2], vv[1], vv[0]});
      for (int k = 0; k < 16; k++) begin
         if (k >= 3 && k <= 10) begin
            vtx_valid_in = 1'b1;
            vtx_in = {4{32'hDEAD_0000 + 32'(k)}};
            n_checks++;
            if (vtx_ready_out !== 1'b0) begin
               n_fail++;
               $display("FAIL hs_ready k=%0d: got %b, expected 0", k, vtx_ready_out);
            end
         end else begin
            vtx_valid_in = 1'b0;
         end
         n_checks++;
         if (b_out !== vv[k % 4]) begin
            n_fail++;
            $display("FAIL hs_b k=%0d: got %h, expected %h", k, b_out, vv[k % 4]);
         end
         tick();
      end
      vtx_valid_in = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL hs_end: got valid=%b, expected 0", valid_out);
      end
   endtask

   initial begin
      rst_in = 1'b1; mat_we_in = 1'b0; mat_addr_in = 4'd0; mat_data_in = 32'h0;
      vtx_valid_in = 1'b0; vtx_in = '0;
      test_reset();
      test_identity();
      test_loaded_element();
      do_reset();
      test_back_to_back();
      test_write_gating();
      test_reset_mid_issue();
      test_handshake_stability();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mat_vec_issue.md
# mat_vec_issue

Operand sequencer directly upstream of `fp32_mul` in the vertex-transform path. It holds a 4x4 FP32 transform matrix and, for each accepted input vertex (x,y,z,w), issues the 16 matrix-element/vector-element operand pairs to the multiplier, one pair per cycle, each tagged with row/column. Downstream adders reduce the four products of each row into one transformed coordinate.

## Interface
Parameters:
- none; dimension fixed at 4x4, data fixed at IEEE-754 binary32.

Ports (reset is synchronous, active-high, single clock domain):
- clk_in  input  1  system clock; all state updates on its rising edge
- rst_in  input  1  synchronous active-high reset
- mat_we_in  input  1  matrix element write enable
- mat_addr_in  input  4  element address {row[1:0], col[1:0]}
- mat_data_in  input  32  FP32 element value
- vtx_valid_in  input  1  input vertex valid
- vtx_ready_out  output  1  block can accept a vertex this cycle
- vtx_in  input  128  {w,z,y,x}; x in [31:0], w in [127:96]
- valid_out  output  1  operand pair valid; drives `fp32_mul` valid_in
- a_out  output  32  matrix element M[row][col]; drives `fp32_mul` a_in
- b_out  output  32  vector element v[col]; drives `fp32_mul` b_in
- row_out  output  2  row index of current pair
- col_out  output  2  column index of current pair
- last_out  output  1  high on pair 15 (final pair) of a vertex
- busy_out  output  1  high while issuing

## Operation
- States: IDLE, ISSUE. Counter k (4 bits) = index of the pair currently on the outputs; row = k[3:2], col = k[1:0].
- IDLE: vtx_ready_out = 1, valid_out = 0. On vtx_valid_in && vtx_ready_out: latch vtx_in, k <= 0, go ISSUE.
- ISSUE: valid_out = 1 every cycle; a_out = M[k[3:2]][k[1:0]], b_out = v[k[1:0]], row_out/col_out = k fields, last_out = (k == 15). k increments each cycle.
- At k == 15: vtx_ready_out = 1. If a vertex is accepted, latch it, k <= 0, remain in ISSUE with no bubble; otherwise go IDLE.
- vtx_ready_out = (state == IDLE) || (state == ISSUE && k == 15); it is combinational from registered state only, never from vtx_valid_in.
- No backpressure from downstream: `fp32_mul` has no ready. Once issuing starts, all 16 pairs go out on consecutive cycles.
- Matrix writes: accepted when busy_out == 0, or when busy_out == 1 && last_out == 1 (the boundary cycle). Writes at all other times are dropped.
- A write on the same edge as a vertex accept is applied before pair 0 is read, so the new vertex sees it.
- Latched vertex registers are unaffected by vtx_in changes when no handshake occurs.
- Tags (row/col/last) must be delayed by the integrator with `pipe`, matched to the `fp32_mul` latency. This block does not delay them.
- Data is passed through bit-exact; no FP interpretation, so NaN/Inf/denormals are not special.

## Timing
- Reset values: state IDLE, k = 0, valid_out = 0, a_out = 0, b_out = 0, row_out = 0, col_out = 0, last_out = 0, busy_out = 0, vtx_ready_out = 1. Matrix resets to identity (0x3F800000 on the diagonal, 0x00000000 elsewhere). Latched vertex resets to 0.
- All outputs except vtx_ready_out are registered.
- Latency: accept at edge E → pair 0 on outputs during the cycle after E. Pair 15 appears 15 cycles later.
- Throughput: one vertex per 16 cycles sustained.
- busy_out == valid_out.
- Reset mid-ISSUE: takes effect at that edge. valid_out = 0 in the following cycle, remaining pairs are discarded, and the matrix returns to identity.
- Reset has priority over the handshake and over matrix writes on the same edge.

## Test plan
- **Identity after reset.** Vertex {x,y,z,w} = {3F800000, 40000000, 40400000, 40800000} → 16 consecutive valid cycles starting 1 cycle after accept. k=0: a=3F800000, b=3F800000. k=1: a=00000000, b=40000000. k=5: a=3F800000, b=40000000. k=15: a=3F800000, b=40800000, last_out=1, asserted only on k=15. valid_out=0 afterwards.
- **Loaded element.** Write M[2][1] = 43970FFD (addr 4'b1001) in IDLE, then vertex with y = 40C91759 → at k=9: a_out=43970FFD, b_out=40C91759, row_out=2, col_out=1.
- **Back-to-back vertices.** vtx_valid_in held high with two vertices → second accepted in the k=15 cycle. Output is 32 consecutive valid cycles with no bubble, and last_out pulses at cycles 15 and 31.
- **Write gating.** Write M[0][0] = 40A00000 at k=7 → dropped; the next vertex still sees 3F800000. The same write issued on the IDLE accept edge → that vertex's k=0 shows a_out=40A00000.
- **Reset mid-issue.** Assert rst_in at k=7 → next cycle valid_out=0, vtx_ready_out=1, last_out=0. A following vertex sees the identity matrix.
- **Handshake stability.** vtx_valid_in pulsed and vtx_in changed at k=3..10 → no acceptance (ready=0), and b_out still reflects the originally latched vertex.
